shift_pipe: RTL and testbench

SHIFT_PIPE -- requirements
Module: shift_pipe

---
 rtl/shift_pipe.sv | 105 ++++++++++
 tb/tb_shift_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// Pipelined logarithmic shifter/rotator: an input capture register followed by SHW shift stages.
// Each stage shifts by 2^k under control of the next remaining amount bit, and the whole pipe stalls together.
module shift_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  // Index 0 is the input capture register; index k (1..SHW) follows shift stage k-1.
  logic             v_q    [SHW+1];
  logic [1:0]       op_q   [SHW+1];
  logic [WIDTH-1:0] data_q [SHW+1];
  logic [SHW-1:0]   amt_q  [SHW+1];
  logic [TAG_W-1:0] tag_q  [SHW+1];
  logic             zero_q;

  logic             v_n    [SHW+1];
  logic [1:0]       op_n   [SHW+1];
  logic [WIDTH-1:0] data_n [SHW+1];
  logic [SHW-1:0]   amt_n  [SHW+1];
  logic [TAG_W-1:0] tag_n  [SHW+1];

  logic stall;

  function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                   input logic [1:0] op,
                                                   input int unsigned sh);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = d << sh;
      OP_SRA:  r = WIDTH'($signed(d) >>> sh);
      OP_ROR:  r = (d >> sh) | (d << (WIDTH - sh));
      OP_SRL:  r = d >> sh;
      default: r = d;
    endcase
    return r;
  endfunction

  assign stall     = v_q[SHW] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v_q[SHW];
  assign out_data  = data_q[SHW];
  assign out_tag   = tag_q[SHW];
  assign out_zero  = zero_q;

  // Next-state of every stage; the remaining amount is shifted so bit 0 always steers the current stage.
  always_comb begin
    v_n[0]    = in_valid;
    op_n[0]   = in_op;
    data_n[0] = in_data;
    amt_n[0]  = in_amt;
    tag_n[0]  = in_tag;
    for (int unsigned k = 1; k <= SHW; k++) begin
      v_n[k]    = v_q[k-1];
      op_n[k]   = op_q[k-1];
      amt_n[k]  = amt_q[k-1] >> 1;
      tag_n[k]  = tag_q[k-1];
      data_n[k] = amt_q[k-1][0] ? stage_shift(data_q[k-1], op_q[k-1], 32'(1) << (k - 1))
                                : data_q[k-1];
    end
  end

  // Reset wins over stall and over a same-cycle request; a stall freezes every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      for (int unsigned k = 0; k <= SHW; k++) begin
        v_q[k]    <= 1'b0;
        op_q[k]   <= '0;
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        tag_q[k]  <= '0;
      end
    end else if (!stall) begin
      zero_q <= ~|data_n[SHW];
      for (int unsigned k = 0; k <= SHW; k++) begin
        v_q[k]    <= v_n[k];
        op_q[k]   <= op_n[k];
        data_q[k] <= data_n[k];
        amt_q[k]  <= amt_n[k];
        tag_q[k]  <= tag_n[k];
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed cases plus randomized traffic against a queue-based reference model.
module tb_shift_pipe;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned SHW   = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;

  shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int stall_cnt = 0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  tag;
    int          acc_cyc;
    int          acc_stall;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: shift/rotate semantics expressed directly on whole words.
  function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] d, input int amt);
    logic [31:0] w;
    logic [15:0] inv;
    w   = {16'h0000, d};
    inv = ~d;
    case (op)
      2'b00:   return 16'(w << amt);
      2'b01:   return d[15] ? ~(inv >> amt) : (d >> amt);
      2'b10:   return 16'((w >> amt) | (w << (16 - amt)));
      default: return 16'(w >> amt);
    endcase
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard: record accepted requests and match every output handshake in order.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && !out_ready) stall_cnt++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("out_without_request", 64'(sb.size()), 64'd1);
        end else begin
          mon_e = sb.pop_front();
          check("data", out_data, mon_e.data);
          check("tag", out_tag, mon_e.tag);
          check("zero", out_zero, mon_e.data == 16'h0000);
          check("latency", 64'(cyc - mon_e.acc_cyc), 64'(SHW + 1 + stall_cnt - mon_e.acc_stall));
        end
      end
      if (in_valid && in_ready)
        sb.push_back('{ref_shift(in_op, in_data, int'(in_amt)), in_tag, cyc, stall_cnt});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] d,
                       input logic [3:0] a, input logic [3:0] t);
    in_valid = v;
    in_op    = op;
    in_data  = d;
    in_amt   = a;
    in_tag   = t;
  endtask

  // Single request into an idle pipe; result must appear exactly SHW edges after acceptance.
  task automatic directed(input string name, input logic [1:0] op, input logic [15:0] d,
                          input logic [3:0] a, input logic [15:0] exp_d);
    drive(1'b1, op, d, a, 4'hA);
    tick();
    drive(1'b0, 2'b00, 16'h0, 4'h0, 4'h0);
    repeat (SHW - 1) tick();
    check({name, "_early"}, out_valid, 1'b0);
    tick();
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_data"}, out_data, exp_d);
    check({name, "_zero"}, out_zero, exp_d == 16'h0000);
    tick();
  endtask

  logic [1:0]  bp_op  [6];
  logic [15:0] bp_dat [6];
  logic [3:0]  bp_amt [6];
  int          amts   [5] = '{0, 1, 7, 8, 15};
  logic [15:0] datas  [4] = '{16'h0000, 16'hFFFF, 16'h8001, 16'h7FFE};

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 2'b00, 16'h0, 4'h0, 4'h0);
    repeat (3) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_out_tag", out_tag, 4'h0);
    check("rst_out_zero", out_zero, 1'b0);
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();

    directed("sll15", 2'b00, 16'h0001, 4'd15, 16'h8000);
    directed("sra4",  2'b01, 16'h8000, 4'd4,  16'hF800);
    directed("srl4",  2'b11, 16'h8000, 4'd4,  16'h0800);
    directed("ror4",  2'b10, 16'h1234, 4'd4,  16'h4123);
    directed("sll1z", 2'b00, 16'h8000, 4'd1,  16'h0000);

    // Back-to-back stream of 8: results on 8 consecutive cycles, tags in order.
    for (int i = 0; i <= 12; i++) begin
      if (i < 8) drive(1'b1, 2'($urandom), 16'($urandom), 4'($urandom), 4'(i));
      else       drive(1'b0, 2'b00, 16'h0, 4'h0, 4'h0);
      tick();
      if (i >= SHW && i < SHW + 8) begin
        check("stream_valid", out_valid, 1'b1);
        check("stream_tag", out_tag, 4'(i - SHW));
      end else begin
        check("stream_gap", out_valid, 1'b0);
      end
    end
    drive(1'b0, 2'b00, 16'h0, 4'h0, 4'h0);
    repeat (4) tick();

    // Backpressure while tag 1 is presented; junk on the input must be ignored.
    for (int i = 0; i < 6; i++) begin
      bp_op[i]  = 2'($urandom);
      bp_dat[i] = 16'($urandom);
      bp_amt[i] = 4'($urandom);
      drive(1'b1, bp_op[i], bp_dat[i], bp_amt[i], 4'(i));
      tick();
    end
    out_ready = 1'b0;
    drive(1'b1, 2'($urandom), 16'($urandom), 4'($urandom), 4'hF);
    repeat (5) begin
      #1;
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_valid", out_valid, 1'b1);
      check("bp_tag_hold", out_tag, 4'd1);
      check("bp_data_hold", out_data, ref_shift(bp_op[1], bp_dat[1], int'(bp_amt[1])));
      tick();
    end
    out_ready = 1'b1;
    drive(1'b0, 2'b00, 16'h0, 4'h0, 4'h0);
    repeat (10) tick();
    check("bp_drained", 64'(sb.size()), 64'd0);

    // Reset with three requests in flight: none of them may emerge.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'($urandom), 16'($urandom | 1), 4'($urandom), 4'(i + 8));
      tick();
    end
    drive(1'b0, 2'b00, 16'h0, 4'h0, 4'h0);
    rst = 1'b1;
    tick();
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("midrst_no_output", out_valid, 1'b0);
    end
    directed("post_rst_srl", 2'b11, 16'h00F0, 4'd4, 16'h000F);

    // Edge grid of ops, amounts and data patterns, one per cycle.
    for (int op = 0; op < 4; op++)
      foreach (amts[a])
        foreach (datas[d]) begin
          drive(1'b1, 2'(op), datas[d], 4'(amts[a]), 4'($urandom));
          tick();
        end
    drive(1'b0, 2'b00, 16'h0, 4'h0, 4'h0);
    repeat (8) tick();
    check("grid_drained", 64'(sb.size()), 64'd0);

    // Random traffic with random backpressure and bubbles.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drive(1'b0, 2'b00, 16'h0, 4'h0, 4'h0);
    out_ready = 1'b1;
    repeat (12) tick();
    check("final_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
